lu_serial_seq: RTL and testbench



---
 rtl/lu_serial_seq_pkg.sv | 13 +
 rtl/lu_serial_seq_if.sv | 26 ++
 rtl/lu_serial_seq_bit.sv | 13 +
 rtl/lu_serial_seq.sv | 109 ++++++++++
 tb/tb_lu_serial_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lu_serial_seq_pkg.sv
// Shared definitions for the bit-serial logic-unit sequencer.
package lu_serial_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_AND = 1'b1;

endpackage

// File: rtl/lu_serial_seq_if.sv
// Word-level request/response bundle between a requester and the sequencer.
interface lu_serial_seq_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ch;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    bit_idx;

  modport master (
    output start, a, b, ch,
    input  ready, busy, done, result, bit_idx
  );

  modport slave (
    input  start, a, b, ch,
    output ready, busy, done, result, bit_idx
  );
endinterface

// File: rtl/lu_serial_seq_bit.sv
// Combinational 1-bit AND/OR unit; the unselected output is gated to 0.
module lu_bit (
  input  logic a,
  input  logic b,
  input  logic ch,
  output logic s_or,
  output logic s_and
);

  assign s_or  = (a | b) & ~ch;
  assign s_and = (a & b) & ch;

endmodule

// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer: feeds one operand bit per clock (LSB first) through
// the shared 1-bit unit and publishes the completed word on finish.
module lu_serial_seq
  import lu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  lu_serial_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  seq_state_t       state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             chReg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] resultReg;
  logic [CW-1:0]    bitIdx;
  logic             readyReg;
  logic             busyReg;
  logic             doneReg;
  logic             sOr;
  logic             sAnd;
  logic             selBit;

  lu_bit u_bit (
    .a     (aReg[bitIdx]),
    .b     (bReg[bitIdx]),
    .ch    (chReg),
    .s_or  (sOr),
    .s_and (sAnd)
  );

  // Pick the unit output matching the captured op and merge it into the word.
  always_comb begin
    selBit          = (chReg == OP_AND) ? sAnd : sOr;
    accNext         = acc;
    accNext[bitIdx] = selBit;
  end

  // Handshake FSM, bit counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      readyReg  <= 1'b1;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      resultReg <= '0;
      bitIdx    <= '0;
      aReg      <= '0;
      bReg      <= '0;
      chReg     <= OP_OR;
      acc       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            aReg     <= bus.a;
            bReg     <= bus.b;
            chReg    <= bus.ch;
            acc      <= '0;
            bitIdx   <= '0;
            state    <= ST_RUN;
            readyReg <= 1'b0;
            busyReg  <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            readyReg <= 1'b1;
            busyReg  <= 1'b0;
          end
        end
        ST_RUN: begin
          acc <= accNext;
          if (bitIdx == LAST_IDX) begin
            // Take the final bit from accNext so result never lags by one bit.
            resultReg <= accNext;
            bitIdx    <= '0;
            state     <= ST_DONE;
            busyReg   <= 1'b0;
            readyReg  <= 1'b1;
            doneReg   <= 1'b1;
          end else begin
            bitIdx <= bitIdx + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          readyReg <= 1'b1;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
          bitIdx   <= '0;
        end
      endcase
    end
  end

  assign bus.ready   = readyReg;
  assign bus.busy    = busyReg;
  assign bus.done    = doneReg;
  assign bus.result  = resultReg;
  assign bus.bit_idx = bitIdx;

endmodule

// File: tb/tb_lu_serial_seq.sv
// Self-checking bench for lu_serial_seq (WIDTH=4).
module tb_lu_serial_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nFails = 0;
  int   cyc = 0;

  lu_serial_seq_if #(.WIDTH(W)) bus ();

  lu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-level reference: OR when ch=0, AND when ch=1.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return c ? (x & y) : (x | y);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request and observe it until done (bounded).
  task automatic do_request(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ich,
                            output logic [W-1:0] res, output int lat, output int busyCycles,
                            output bit readySeenInRun, output bit readyAtDone);
    busyCycles = 0;
    readySeenInRun = 1'b0;
    bus.a = ia;
    bus.b = ib;
    bus.ch = ich;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.ready !== 1'b0) readySeenInRun = 1'b1;
      tick();
      lat++;
    end
    res = bus.result;
    readyAtDone = bus.ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ch = 1'b0;
    repeat (2) tick();
    nChecks++; if (bus.ready !== 1'b1) begin nFails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", bus.done); end
    nChecks++; if (bus.result !== 4'b0000) begin nFails++; $display("FAIL reset_result got %b want 0000", bus.result); end
    nChecks++; if (bus.bit_idx !== 2'd0) begin nFails++; $display("FAIL reset_bit_idx got %0d want 0", bus.bit_idx); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_or();
    logic [W-1:0] r; int lat; int bc; bit rr; bit rd;
    do_request(4'b0101, 4'b0011, 1'b0, r, lat, bc, rr, rd);
    nChecks++; if (r !== 4'b0111) begin nFails++; $display("FAIL or_result got %b want 0111", r); end
    nChecks++; if (lat !== W + 1) begin nFails++; $display("FAIL or_latency got %0d want %0d", lat, W + 1); end
    nChecks++; if (bc !== W) begin nFails++; $display("FAIL or_busy_cycles got %0d want %0d", bc, W); end
    tick();
    nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL or_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_and_ready();
    logic [W-1:0] r; int lat; int bc; bit rr; bit rd;
    do_request(4'b0101, 4'b0011, 1'b1, r, lat, bc, rr, rd);
    nChecks++; if (r !== 4'b0001) begin nFails++; $display("FAIL and_result got %b want 0001", r); end
    nChecks++; if (rr !== 1'b0) begin nFails++; $display("FAIL and_ready_in_run got %b want 0", rr); end
    nChecks++; if (rd !== 1'b1) begin nFails++; $display("FAIL and_ready_at_done got %b want 1", rd); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat = 0; int extraDone = 0;
    bus.a = 4'b0101; bus.b = 4'b0011; bus.ch = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 4'b1111; bus.b = 4'b1111; bus.ch = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 20) begin tick(); lat++; end
    nChecks++; if (bus.result !== 4'b0111) begin nFails++; $display("FAIL ignore_result got %b want 0111", bus.result); end
    nChecks++; if (lat !== W + 1) begin nFails++; $display("FAIL ignore_latency got %0d want %0d", lat, W + 1); end
    for (int i = 0; i < 8; i++) begin tick(); if (bus.done === 1'b1) extraDone++; end
    nChecks++; if (extraDone !== 0) begin nFails++; $display("FAIL ignore_extra_done got %0d want 0", extraDone); end
  endtask

  task automatic test_reset_mid_run();
    int extraDone = 0;
    bus.a = 4'b1111; bus.b = 4'b0000; bus.ch = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL midrst_done got %b want 0", bus.done); end
    nChecks++; if (bus.result !== 4'b0000) begin nFails++; $display("FAIL midrst_result got %b want 0000", bus.result); end
    nChecks++; if (bus.ready !== 1'b1) begin nFails++; $display("FAIL midrst_ready got %b want 1", bus.ready); end
    for (int i = 0; i < 8; i++) begin tick(); if (bus.done === 1'b1) extraDone++; end
    nChecks++; if (extraDone !== 0) begin nFails++; $display("FAIL midrst_late_done got %0d want 0", extraDone); end
  endtask

  task automatic test_back_to_back();
    int t0 = 0; int t1 = 0; int lat = 0;
    bus.a = 4'b1010; bus.b = 4'b1100; bus.ch = 1'b0; bus.start = 1'b1;
    tick();
    bus.ch = 1'b1;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin tick(); lat++; end
    t0 = cyc;
    nChecks++; if (bus.result !== 4'b1110) begin nFails++; $display("FAIL b2b_first got %b want 1110", bus.result); end
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin tick(); lat++; end
    t1 = cyc;
    nChecks++; if (bus.result !== 4'b1000) begin nFails++; $display("FAIL b2b_second got %b want 1000", bus.result); end
    nChecks++; if (t1 - t0 !== W + 1) begin nFails++; $display("FAIL b2b_spacing got %0d want %0d", t1 - t0, W + 1); end
    tick();
  endtask

  task automatic test_bit_idx();
    logic [W-1:0] r; int lat; int bc; bit rr; bit rd;
    bus.a = 4'b1111; bus.b = 4'b1111; bus.ch = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      nChecks++; if (bus.bit_idx !== 2'(i)) begin nFails++; $display("FAIL bit_idx_seq[%0d] got %0d want %0d", i, bus.bit_idx, i); end
      tick();
    end
    nChecks++; if (bus.done !== 1'b1 || bus.result !== 4'b1111) begin nFails++; $display("FAIL ones_and got done=%b result=%b want done=1 result=1111", bus.done, bus.result); end
    tick();
    do_request(4'b0000, 4'b0000, 1'b0, r, lat, bc, rr, rd);
    nChecks++; if (r !== 4'b0000) begin nFails++; $display("FAIL zeros_or got %b want 0000", r); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] ra; logic [W-1:0] rb; logic rc; logic [W-1:0] r;
    int lat; int bc; bit rr; bit rd;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_request(ra, rb, rc, r, lat, bc, rr, rd);
      nChecks++;
      if (r !== model(ra, rb, rc) || lat !== W + 1) begin
        nFails++;
        $display("FAIL random[%0d] a=%b b=%b ch=%b got result=%b lat=%0d want result=%b lat=%0d",
                 i, ra, rb, rc, r, lat, model(ra, rb, rc), W + 1);
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ch = 1'b0;
    @(negedge clk);
    test_reset();
    test_or();
    test_and_ready();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_bit_idx();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
